// File: rtl/cmul_pkg.sv
// Shared widths, saturation bounds and mode constants for the complex multiplier
// and the FFT butterfly/scaler blocks that reuse its rounding stage.
package cmul_pkg;

    localparam int ROUND_TRUNC   = 0;
    localparam int ROUND_HALF_UP = 1;
    localparam int SAT_WRAP      = 0;
    localparam int SAT_CLIP      = 1;

    localparam int DEF_N = 16;
    localparam logic [DEF_N-1:0] DEF_SAT_MAX = {1'b0, {(DEF_N-1){1'b1}}};
    localparam logic [DEF_N-1:0] DEF_SAT_MIN = {1'b1, {(DEF_N-1){1'b0}}};

    function automatic int prod_w(input int n);
        return 2 * n;
    endfunction

    // One guard bit above the product so a +/- of two extreme products never overflows.
    function automatic int sum_w(input int n);
        return 2 * n + 1;
    endfunction

endpackage

// File: rtl/cmul_round_sat.sv
// Combinational scaler: optional round-half-up, arithmetic shift by Q, then
// saturate or wrap a (2N+1)-bit value to N bits and flag any out-of-range result.
module cmul_round_sat
    import cmul_pkg::*;
#(
    parameter int N     = 16,
    parameter int Q     = 8,
    parameter int ROUND = ROUND_HALF_UP,
    parameter int SAT   = SAT_CLIP
) (
    input  logic signed [sum_w(N)-1:0] din,
    output logic        [N-1:0]        dout,
    output logic                       ovf
);

    localparam int SW = sum_w(N);
    localparam logic signed [SW-1:0] HALF  = (ROUND == ROUND_HALF_UP) ? (SW'(1) << (Q - 1)) : '0;
    localparam logic signed [SW-1:0] MAX_S = (SW'(1) << (N - 1)) - SW'(1);
    localparam logic signed [SW-1:0] MIN_S = -(SW'(1) << (N - 1));
    localparam logic [N-1:0] MAX_N = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MIN_N = {1'b1, {(N-1){1'b0}}};

    logic signed [SW-1:0] rounded;
    logic signed [SW-1:0] shifted;
    logic                 too_hi;
    logic                 too_lo;

    // NOTE: every signal is given a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        rounded = din + HALF;
        shifted = rounded >>> Q;
        too_hi  = shifted > MAX_S;
        too_lo  = shifted < MIN_S;
        ovf     = too_hi || too_lo;
        dout    = shifted[N-1:0];
        if (SAT == SAT_CLIP) begin
            if (too_hi) dout = MAX_N;
            if (too_lo) dout = MIN_N;
        end
    end

endmodule

// File: rtl/cmul_pipe.sv
// Three-stage fixed-point complex multiplier z = x1*x2 or x1*conj(x2) with a single
// shared advance enable: products, then re/im sums, then round/saturate.
module cmul_pipe
    import cmul_pkg::*;
#(
    parameter int N     = 16,
    parameter int Q     = 8,
    parameter int ROUND = ROUND_HALF_UP,
    parameter int SAT   = SAT_CLIP
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         conj,
    input  logic [N-1:0] x1_real,
    input  logic [N-1:0] x1_imag,
    input  logic [N-1:0] x2_real,
    input  logic [N-1:0] x2_imag,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] z_real,
    output logic [N-1:0] z_imag,
    output logic         ovf
);

    localparam int PW = prod_w(N);
    localparam int SW = sum_w(N);

    logic adv;
    logic s1_valid_d, s1_valid_q;
    logic s2_valid_d, s2_valid_q;
    logic s3_valid_d, s3_valid_q;

    logic signed [PW-1:0] ac_d, ac_q, bd_d, bd_q, ad_d, ad_q, bc_d, bc_q;
    logic                 conj_d, conj_q;
    logic signed [SW-1:0] re_d, re_q, im_d, im_q;
    logic        [N-1:0]  z_real_d, z_real_q, z_imag_d, z_imag_q;
    logic                 ovf_d, ovf_q;

    logic [N-1:0] rs_re, rs_im;
    logic         rs_ovf_re, rs_ovf_im;

    cmul_round_sat #(.N(N), .Q(Q), .ROUND(ROUND), .SAT(SAT)) u_rs_re (
        .din  (re_q),
        .dout (rs_re),
        .ovf  (rs_ovf_re)
    );

    cmul_round_sat #(.N(N), .Q(Q), .ROUND(ROUND), .SAT(SAT)) u_rs_im (
        .din  (im_q),
        .dout (rs_im),
        .ovf  (rs_ovf_im)
    );

    always_comb begin
        adv        = !s3_valid_q || out_ready;
        s1_valid_d = adv ? in_valid   : s1_valid_q;
        s2_valid_d = adv ? s1_valid_q : s2_valid_q;
        s3_valid_d = adv ? s2_valid_q : s3_valid_q;

        ac_d     = ac_q;
        bd_d     = bd_q;
        ad_d     = ad_q;
        bc_d     = bc_q;
        conj_d   = conj_q;
        re_d     = re_q;
        im_d     = im_q;
        z_real_d = z_real_q;
        z_imag_d = z_imag_q;
        ovf_d    = ovf_q;

        // Each stage only loads when a real sample moves into it, so held data never churns.
        if (adv && in_valid) begin
            ac_d   = PW'($signed(x1_real)) * PW'($signed(x2_real));
            bd_d   = PW'($signed(x1_imag)) * PW'($signed(x2_imag));
            ad_d   = PW'($signed(x1_real)) * PW'($signed(x2_imag));
            bc_d   = PW'($signed(x1_imag)) * PW'($signed(x2_real));
            conj_d = conj;
        end

        if (adv && s1_valid_q) begin
            re_d = conj_q ? (SW'(ac_q) + SW'(bd_q)) : (SW'(ac_q) - SW'(bd_q));
            im_d = conj_q ? (SW'(bc_q) - SW'(ad_q)) : (SW'(ad_q) + SW'(bc_q));
        end

        if (adv && s2_valid_q) begin
            z_real_d = rs_re;
            z_imag_d = rs_im;
            ovf_d    = rs_ovf_re || rs_ovf_im;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            z_real_q   <= '0;
            z_imag_q   <= '0;
            ovf_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every stage samples the pre-edge value of the one before it.
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s3_valid_q <= s3_valid_d;
            z_real_q   <= z_real_d;
            z_imag_q   <= z_imag_d;
            ovf_q      <= ovf_d;
        end
    end

    // NOTE: inner datapath registers carry no reset; their contents are ignored until the valid bit beside them is set.
    always_ff @(posedge clk) begin
        ac_q   <= ac_d;
        bd_q   <= bd_d;
        ad_q   <= ad_d;
        bc_q   <= bc_d;
        conj_q <= conj_d;
        re_q   <= re_d;
        im_q   <= im_d;
    end

    assign in_ready  = adv;
    assign out_valid = s3_valid_q;
    assign z_real    = z_real_q;
    assign z_imag    = z_imag_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cmul_pipe.sv
// Scoreboard bench: three instances (round+sat, trunc+sat, round+wrap) share one
// stimulus stream; expected results are queued on accept and compared on output.
module tb_cmul_pipe;

    typedef struct {
        logic [2:0][15:0] re;
        logic [2:0][15:0] im;
        logic [2:0]       ov;
        int               acc;
        bit               lat;
        logic [2:0]       lmask;
        logic [2:0][15:0] lre;
        logic [2:0][15:0] lim;
        logic [2:0]       lov;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        conj_in = 1'b0;
    logic [15:0] x1r = '0, x1i = '0, x2r = '0, x2i = '0;

    logic [2:0]  rdy, ov, ovfv;
    logic [15:0] zr [3];
    logic [15:0] zi [3];

    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    logic [2:0] m_v = '0;
    bit   rand_rdy = 1'b0;
    bit   cur_lat  = 1'b0;
    logic [2:0]       cur_lmask = '0;
    logic [2:0][15:0] cur_lre = '0, cur_lim = '0;
    logic [2:0]       cur_lov = '0;
    ent_t sb [$];

    cmul_pipe #(.N(16), .Q(8), .ROUND(1), .SAT(1)) dut_rs (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .conj(conj_in),
        .x1_real(x1r), .x1_imag(x1i), .x2_real(x2r), .x2_imag(x2i),
        .out_valid(ov[0]), .out_ready(out_ready), .z_real(zr[0]), .z_imag(zi[0]), .ovf(ovfv[0])
    );

    cmul_pipe #(.N(16), .Q(8), .ROUND(0), .SAT(1)) dut_ts (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .conj(conj_in),
        .x1_real(x1r), .x1_imag(x1i), .x2_real(x2r), .x2_imag(x2i),
        .out_valid(ov[1]), .out_ready(out_ready), .z_real(zr[1]), .z_imag(zi[1]), .ovf(ovfv[1])
    );

    cmul_pipe #(.N(16), .Q(8), .ROUND(1), .SAT(0)) dut_rw (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .conj(conj_in),
        .x1_real(x1r), .x1_imag(x1i), .x2_real(x2r), .x2_imag(x2i),
        .out_valid(ov[2]), .out_ready(out_ready), .z_real(zr[2]), .z_imag(zi[2]), .ovf(ovfv[2])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic void scale(input longint s, input bit rnd, input bit sat,
                                  output logic [15:0] v, output logic o);
        longint t;
        t = rnd ? s + 64'sd128 : s;
        t = t >>> 8;
        o = (t > 64'sd32767) || (t < -64'sd32768);
        v = t[15:0];
        if (sat && t > 64'sd32767)  v = 16'h7fff;
        if (sat && t < -64'sd32768) v = 16'h8000;
    endfunction

    function automatic void model(input logic [15:0] a, b, c, d, input bit cj, rnd, sat,
                                  output logic [15:0] r, output logic [15:0] i, output logic o);
        longint ac, bd, ad, bc, re, im;
        logic o1, o2;
        ac = longint'($signed(a)) * longint'($signed(c));
        bd = longint'($signed(b)) * longint'($signed(d));
        ad = longint'($signed(a)) * longint'($signed(d));
        bc = longint'($signed(b)) * longint'($signed(c));
        re = cj ? ac + bd : ac - bd;
        im = cj ? bc - ad : ad + bc;
        scale(re, rnd, sat, r, o1);
        scale(im, rnd, sat, i, o2);
        o = o1 | o2;
    endfunction

    // Reference pipeline occupancy plus scoreboard, evaluated mid-cycle.
    always @(negedge clk) begin
        logic exp_adv;
        ent_t e;
        if (rst) begin
            m_v = '0;
            sb.delete();
        end else begin
            exp_adv = !m_v[2] || out_ready;
            for (int i = 0; i < 3; i++) begin
                check($sformatf("in_ready%0d", i), 32'(rdy[i]), 32'(exp_adv));
                check($sformatf("out_valid%0d", i), 32'(ov[i]), 32'(m_v[2]));
            end
            if (m_v[2] && sb.size() > 0) begin
                e = sb[0];
                for (int i = 0; i < 3; i++) begin
                    check($sformatf("z_real%0d", i), 32'(zr[i]), 32'(e.re[i]));
                    check($sformatf("z_imag%0d", i), 32'(zi[i]), 32'(e.im[i]));
                    check($sformatf("ovf%0d", i), 32'(ovfv[i]), 32'(e.ov[i]));
                end
                if (out_ready) begin
                    if (e.lat) check("latency", 32'(cyc - e.acc), 32'd3);
                    for (int i = 0; i < 3; i++) begin
                        if (e.lmask[i]) begin
                            check($sformatf("lit_re%0d", i), 32'(zr[i]), 32'(e.lre[i]));
                            check($sformatf("lit_im%0d", i), 32'(zi[i]), 32'(e.lim[i]));
                            check($sformatf("lit_ovf%0d", i), 32'(ovfv[i]), 32'(e.lov[i]));
                        end
                    end
                    void'(sb.pop_front());
                end
            end
            if (in_valid && exp_adv) begin
                for (int i = 0; i < 3; i++) begin
                    logic [15:0] r, im;
                    logic o;
                    model(x1r, x1i, x2r, x2i, conj_in, i != 1, i != 2, r, im, o);
                    e.re[i] = r;
                    e.im[i] = im;
                    e.ov[i] = o;
                end
                e.acc   = cyc;
                e.lat   = cur_lat;
                e.lmask = cur_lmask;
                e.lre   = cur_lre;
                e.lim   = cur_lim;
                e.lov   = cur_lov;
                sb.push_back(e);
            end
            if (exp_adv) m_v = {m_v[1:0], in_valid};
        end
    end

    task automatic lit_clear();
        cur_lmask = '0;
    endtask

    task automatic lit_set(input int i, input logic [15:0] r, input logic [15:0] im, input logic o);
        cur_lmask[i] = 1'b1;
        cur_lre[i]   = r;
        cur_lim[i]   = im;
        cur_lov[i]   = o;
    endtask

    task automatic send(input logic [15:0] a, b, c, d, input bit cj, input bit lat);
        bit done;
        done     = 1'b0;
        x1r      = a;
        x1i      = b;
        x2r      = c;
        x2i      = d;
        conj_in  = cj;
        cur_lat  = lat;
        in_valid = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (rdy[0]) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        check("send_timeout", 32'(done), 32'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && sb.size() > 0; n++) @(negedge clk);
        check("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_out_valid", 32'(ov[0]), 32'd0);
        check("rst_z_real", 32'(zr[0]), 32'd0);
        check("rst_z_imag", 32'(zi[0]), 32'd0);
        check("rst_ovf", 32'(ovfv[0]), 32'd0);
        check("rst_in_ready", 32'(rdy[0]), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed cases, streamed back to back with out_ready high.
        lit_clear(); lit_set(0, 16'h0300, 16'h0000, 1'b0);
        send(16'h0180, 16'h0000, 16'h0200, 16'h0000, 1'b0, 1'b1);
        lit_clear(); lit_set(0, 16'h0000, 16'h0200, 1'b0);
        send(16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b0, 1'b1);
        lit_clear(); lit_set(0, 16'h0200, 16'h0000, 1'b0);
        send(16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b1, 1'b1);
        lit_clear(); lit_set(0, 16'h0001, 16'h0000, 1'b0); lit_set(1, 16'h0000, 16'h0000, 1'b0);
        send(16'h0001, 16'h0000, 16'h0080, 16'h0000, 1'b0, 1'b1);
        lit_clear(); lit_set(0, 16'h0000, 16'h0000, 1'b0); lit_set(1, 16'hffff, 16'h0000, 1'b0);
        send(16'hffff, 16'h0000, 16'h0080, 16'h0000, 1'b0, 1'b1);
        lit_clear(); lit_set(0, 16'h7fff, 16'h0000, 1'b1); lit_set(2, 16'h0000, 16'h0000, 1'b1);
        send(16'h8000, 16'h0000, 16'h8000, 16'h0000, 1'b0, 1'b1);
        lit_clear(); lit_set(0, 16'h8000, 16'h0000, 1'b1);
        send(16'h8000, 16'h0000, 16'h7fff, 16'h0000, 1'b0, 1'b1);
        lit_clear(); lit_set(0, 16'h7fff, 16'h0000, 1'b1);
        send(16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b1, 1'b1);
        lit_clear();
        drain();

        // Random stream under pseudo-random back-pressure.
        rand_rdy = 1'b1;
        for (int k = 0; k < 20; k++)
            send(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        @(posedge clk);
        #1;
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset with three samples in flight.
        send(16'h0100, 16'h0000, 16'h0100, 16'h0000, 1'b0, 1'b1);
        send(16'h0200, 16'h0000, 16'h0100, 16'h0000, 1'b0, 1'b1);
        send(16'h0300, 16'h0000, 16'h0100, 16'h0000, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) check($sformatf("midrst_out_valid%0d", i), 32'(ov[i]), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(rdy[0]), 32'd1);
        @(posedge clk);
        #1;
        lit_clear(); lit_set(0, 16'h0300, 16'h0000, 1'b0);
        send(16'h0180, 16'h0000, 16'h0200, 16'h0000, 1'b0, 1'b1);
        lit_clear();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
